// File: rtl/key_dpram_ctrl_if.sv
// Key-event inputs, RAM port A/B signals and status outputs of the DPRAM test sequencer.
// slave = sequencer side, master = key filters / RAM / display side.
interface key_dpram_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          fill_flag;
  logic          fill_state;
  logic          vfy_flag;
  logic          vfy_state;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   err_cnt;
  logic [DW-1:0] seed;

  modport slave (
    input  fill_flag, fill_state, vfy_flag, vfy_state, rd_data,
    output wr_en, wr_addr, wr_data, rd_addr, busy, done, err, err_cnt, seed
  );

  modport master (
    output fill_flag, fill_state, vfy_flag, vfy_state, rd_data,
    input  wr_en, wr_addr, wr_data, rd_addr, busy, done, err, err_cnt, seed
  );
endinterface

// File: rtl/key_dpram_ctrl.sv
// Key-driven DPRAM sequencer: FILL writes addr+seed over port A, VERIFY reads back over port B
// and counts mismatches through an RD_LAT-deep expected-data pipeline. All outputs registered.
module key_dpram_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input logic            Clk,
  input logic            Rst_n,
  key_dpram_ctrl_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(1) << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_VFY   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [AW:0]   cnt_q,     cnt_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [DW-1:0] seed_q,    seed_d;

  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [DW-1:0]     pe_q [RD_LAT];
  logic [DW-1:0]     pe_d [RD_LAT];

  logic fill_press, vfy_press, issue;
  logic [DW-1:0] cur_pat;

  assign fill_press = bus.fill_flag & ~bus.fill_state;
  assign vfy_press  = bus.vfy_flag  & ~bus.vfy_state;
  // Address is zero-extended or truncated to DW before adding the seed.
  assign cur_pat    = DW'(cnt_q[AW-1:0]) + seed_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    seed_d    = seed_q;
    issue     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fill_press) begin
          state_d   = S_FILL;
          seed_d    = seed_q + DW'(1);
          cnt_d     = '0;
          err_d     = 1'b0;
          err_cnt_d = '0;
          busy_d    = 1'b1;
        end else if (vfy_press) begin
          state_d   = S_VFY;
          cnt_d     = '0;
          err_d     = 1'b0;
          err_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_FILL: begin
        if (cnt_q == DEPTH_C) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[AW-1:0];
          wr_data_d = cur_pat;
          cnt_d     = cnt_q + (AW+1)'(1);
        end
      end
      S_VFY: begin
        if (cnt_q == DEPTH_C) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = cnt_q[AW-1:0];
          issue     = 1'b1;
          cnt_d     = cnt_q + (AW+1)'(1);
        end
      end
      default: begin
        // DRAIN: finish once every outstanding read has been compared.
        if (pv_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase

    if (pv_q[RD_LAT-1] && (bus.rd_data != pe_q[RD_LAT-1])) begin
      err_d = 1'b1;
      if (err_cnt_q != DEPTH_C) err_cnt_d = err_cnt_q + (AW+1)'(1);
    end

    pv_d[0] = issue;
    pe_d[0] = cur_pat;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      seed_q    <= '0;
      pv_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) pe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      seed_q    <= seed_d;
      pv_q      <= pv_d;
      for (int i = 0; i < RD_LAT; i++) pe_q[i] <= pe_d[i];
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.seed    = seed_q;

endmodule

// File: tb/tb_key_dpram_ctrl.sv
// Bench for key_dpram_ctrl (AW=4, DW=8, RD_LAT=2) with a behavioural DPRAM and
// write/done scoreboards filled at key-press time and drained by negedge monitors.
module tb_key_dpram_ctrl;

  logic Clk;
  logic Rst_n;
  logic flip;

  key_dpram_ctrl_if #(.AW(4), .DW(8)) bus ();

  key_dpram_ctrl #(.AW(4), .DW(8), .RD_LAT(2)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic err; logic [4:0] cnt; logic [7:0] seed; } done_t;

  wr_t   wq[$];
  done_t dq[$];
  int    n_tests;
  int    n_fail;
  logic [7:0] exp_seed;
  logic [7:0] mem [16];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Port-B register stage: rd_addr set at edge c is sampled by the DUT at edge c+2.
  always @(posedge Clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    bus.rd_data <= mem[bus.rd_addr] ^ {7'b0, flip && (bus.rd_addr == 4'd5 || bus.rd_addr == 4'd15)};
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (bus.wr_en) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none required", bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== {e.a, e.d}) begin
            n_fail++;
            $display("FAIL write: got addr %0h data %0h, want addr %0h data %0h",
                     bus.wr_addr, bus.wr_data, e.a, e.d);
          end
        end
      end
      if (bus.done) begin
        n_tests++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done pulse with no operation outstanding");
        end else begin
          done_t e;
          e = dq.pop_front();
          if ({bus.err, bus.err_cnt, bus.seed} !== {e.err, e.cnt, e.seed}) begin
            n_fail++;
            $display("FAIL done_result: got err %0b cnt %0d seed %0h, want err %0b cnt %0d seed %0h",
                     bus.err, bus.err_cnt, bus.seed, e.err, e.cnt, e.seed);
          end
        end
      end
    end
  end

  task automatic press(input logic f, input logic v, input logic st);
    bus.fill_flag  = f;
    bus.vfy_flag   = v;
    bus.fill_state = st;
    bus.vfy_state  = st;
    @(negedge Clk);
    bus.fill_flag  = 1'b0;
    bus.vfy_flag   = 1'b0;
    bus.fill_state = 1'b1;
    bus.vfy_state  = 1'b1;
  endtask

  task automatic push_fill();
    exp_seed = exp_seed + 8'd1;
    for (int a = 0; a < 16; a++) wq.push_back('{4'(a), 8'(a) + exp_seed});
    dq.push_back('{1'b0, 5'd0, exp_seed});
  endtask

  task automatic wait_done(input int exp_k, input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      if (bus.done) begin
        k = i;
        break;
      end
    end
    n_tests++;
    if (k != exp_k) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got t+%0d (0 = timeout), want t+%0d", name, k, exp_k);
    end
    @(negedge Clk);
    n_tests++;
    if ({bus.done, bus.busy, bus.wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_after_done: got done/busy/wr_en %b, want 000", name, {bus.done, bus.busy, bus.wr_en});
    end
  endtask

  task automatic idle_check(input int cycles, input string name);
    int nb;
    nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (bus.busy || bus.wr_en) nb++;
    end
    n_tests++;
    if (nb != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d busy cycles, want 0", name, nb);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (10) @(negedge Clk);
    n_tests++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.busy, bus.done,
         bus.err, bus.err_cnt, bus.seed} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    n_tests++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_addr, bus.busy, bus.done,
         bus.err, bus.err_cnt, bus.seed} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got nonzero outputs after reset release, want all 0");
    end
  endtask

  task automatic test_fill();
    push_fill();
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({bus.busy, bus.seed} !== {1'b1, exp_seed}) begin
      n_fail++;
      $display("FAIL fill_entry: got busy %b seed %0h, want busy 1 seed %0h", bus.busy, bus.seed, exp_seed);
    end
    wait_done(17, "fill");
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL fill_write_count: got %0d writes missing, want 0", wq.size());
    end
  endtask

  task automatic test_verify(input logic flip_en, input logic [4:0] exp_cnt);
    flip = flip_en;
    dq.push_back('{flip_en, exp_cnt, exp_seed});
    press(1'b0, 1'b1, 1'b0);
    wait_done(19, flip_en ? "verify_err" : "verify_ok");
    n_tests++;
    if ({bus.err, bus.err_cnt} !== {flip_en, exp_cnt}) begin
      n_fail++;
      $display("FAIL verify_result: got err %0b cnt %0d, want err %0b cnt %0d",
               bus.err, bus.err_cnt, flip_en, exp_cnt);
    end
    flip = 1'b0;
  endtask

  task automatic test_fill_clears_err();
    push_fill();
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({bus.err, bus.err_cnt} !== 6'd0) begin
      n_fail++;
      $display("FAIL fill_clears_err: got err %0b cnt %0d, want 0 0", bus.err, bus.err_cnt);
    end
    wait_done(17, "fill_after_err");
  endtask

  task automatic test_arbitration();
    push_fill();
    press(1'b1, 1'b1, 1'b0);
    wait_done(17, "both_press");
    idle_check(25, "no_verify_after_both");
    push_fill();
    press(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge Clk);
    press(1'b0, 1'b1, 1'b0);
    wait_done(12, "vfy_mid_fill");
    idle_check(25, "vfy_mid_fill_dropped");
    press(1'b1, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b1);
    idle_check(10, "release_ignored");
  endtask

  task automatic test_reset_mid();
    push_fill();
    press(1'b1, 1'b0, 1'b0);
    repeat (7) @(negedge Clk);
    n_tests++;
    if ({bus.wr_en, bus.wr_addr} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL mid_fill_position: got wr_en %b addr %0d, want 1 6", bus.wr_en, bus.wr_addr);
    end
    #2 Rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.wr_en, bus.busy, bus.done, bus.seed} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got wr_en %b busy %b done %b seed %0h, want 0 0 0 0",
               bus.wr_en, bus.busy, bus.done, bus.seed);
    end
    wq.delete();
    dq.delete();
    exp_seed = 8'd0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    idle_check(3, "post_abort_idle");
    test_fill();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_seed = 8'd0;
    flip = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.fill_flag  = 1'b0;
    bus.vfy_flag   = 1'b0;
    bus.fill_state = 1'b1;
    bus.vfy_state  = 1'b1;
    Rst_n = 1'b0;
    @(negedge Clk);
    test_reset();
    test_fill();
    test_verify(1'b0, 5'd0);
    test_verify(1'b1, 5'd2);
    test_fill_clears_err();
    test_arbitration();
    test_reset_mid();
    idle_check(5, "final_idle");
    n_tests++;
    if (dq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d done / %0d writes outstanding, want 0 / 0", dq.size(), wq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
